// File: rtl/controlador_maquina_pkg.sv
// maquina_pkg: FSM states, default prices, valid coin set, lowest-index selection and SR>SP>SN error priority
package maquina_pkg;
  typedef enum logic [1:0] {ESPERA, PAGAMENTO, PREPARO, ERRO} estado_t;
  localparam int PRECO [4] = '{1, 2, 5, 10};
  localparam int W_TEMPO = 16;
  function automatic logic moeda_valida(input logic [3:0] m);
    return m inside {4'd1, 4'd2, 4'd5, 4'd10};
  endfunction
  function automatic logic [1:0] sel_de(input logic [3:0] b);
    return b[0] ? 2'd0 : b[1] ? 2'd1 : b[2] ? 2'd2 : 2'd3;
  endfunction
  function automatic logic [2:0] erro_prio(input logic fsr, input logic fsp, input logic fsn);
    return fsr ? 3'b100 : fsp ? 3'b010 : fsn ? 3'b001 : 3'b000;
  endfunction
endpackage

// File: rtl/controlador_maquina_if.sv
// controlador_maquina_if: machine bus; slave (DUT) takes B/MOEDA/MOEDA_V/CANCELA/FSx, drives S0..S3/SR/SP/SN/VL/M/LIBERA/TROCO/TROCO_V
interface controlador_maquina_if #(parameter int W_CREDITO = 5);
  logic [3:0] B;
  logic [3:0] MOEDA;
  logic MOEDA_V, CANCELA, FSR, FSP, FSN;
  logic S0, S1, S2, S3, SR, SP, SN, VL, M, LIBERA;
  logic [W_CREDITO-1:0] TROCO;
  logic TROCO_V;
  modport master (output B, MOEDA, MOEDA_V, CANCELA, FSR, FSP, FSN,
                  input S0, S1, S2, S3, SR, SP, SN, VL, M, LIBERA, TROCO, TROCO_V);
  modport slave (input B, MOEDA, MOEDA_V, CANCELA, FSR, FSP, FSN,
                 output S0, S1, S2, S3, SR, SP, SN, VL, M, LIBERA, TROCO, TROCO_V);
endinterface

// File: rtl/controlador_maquina_temporizador.sv
// temporizador: loadable down-counter (CLK, RST, ld_i, en_i, val_i in; done_o pulses on the last counted cycle)
module temporizador #(parameter int W = 16) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         ld_i,
  input  logic         en_i,
  input  logic [W-1:0] val_i,
  output logic         done_o
);
  logic [W-1:0] cnt_q;
  always_ff @(posedge CLK or posedge RST)
    if (RST) cnt_q <= '0;
    else if (ld_i) cnt_q <= val_i;
    else if (en_i && cnt_q != '0) cnt_q <= cnt_q - 1'b1;
  assign done_o = en_i && cnt_q == W'(1);
endmodule

// File: rtl/controlador_maquina.sv
// controlador_maquina: coffee machine control FSM (CLK, RST, io slave bus: buttons/coins/faults in, selection/error/mode/valve/change out)
module controlador_maquina import maquina_pkg::*; #(
  parameter int PRECO_S0    = PRECO[0],
  parameter int PRECO_S1    = PRECO[1],
  parameter int PRECO_S2    = PRECO[2],
  parameter int PRECO_S3    = PRECO[3],
  parameter int W_CREDITO   = 5,
  parameter int T_PAGAMENTO = 1000,
  parameter int T_PREPARO   = 500,
  parameter int T_ERRO_VL   = 200
) (
  input logic CLK,
  input logic RST,
  controlador_maquina_if.slave io
);
  localparam int PR [4] = '{PRECO_S0, PRECO_S1, PRECO_S2, PRECO_S3};
  estado_t st_q, st_d;
  logic [1:0] sel_q, sel_d;
  logic [W_CREDITO-1:0] cred_q, cred_d, cred_n, preco, moeda, troco_d, troco_q;
  logic [3:0] s_q, s_d;
  logic [2:0] e_q, e_d;
  logic m_q, lib_q, tv_q, vl_q, valida, falha, t_ld, t_done, vl_ld, vl_done;
  temporizador #(.W(W_TEMPO)) u_tempo (
    .CLK(CLK), .RST(RST), .ld_i(t_ld), .en_i(1'b1),
    .val_i(st_d == PREPARO ? W_TEMPO'(T_PREPARO) : W_TEMPO'(T_PAGAMENTO)), .done_o(t_done)
  );
  temporizador #(.W(W_TEMPO)) u_vl (
    .CLK(CLK), .RST(RST), .ld_i(vl_ld), .en_i(1'b1),
    .val_i(W_TEMPO'(T_ERRO_VL)), .done_o(vl_done)
  );
  // Any coin not taken as credit is handed back; troco_d == 0 means no strobe.
  always_comb begin
    moeda = io.MOEDA_V ? W_CREDITO'(io.MOEDA) : '0;
    valida = io.MOEDA_V && moeda_valida(io.MOEDA);
    falha = io.FSR || io.FSP || io.FSN;
    preco = W_CREDITO'(PR[sel_q]);
    cred_n = st_q == PAGAMENTO ? cred_q + (valida ? moeda : '0) : '0;
    st_d = st_q;
    sel_d = sel_q;
    troco_d = moeda;
    vl_ld = 1'b0;
    if (falha) begin
      st_d = ERRO;
      troco_d = moeda + (st_q == PAGAMENTO ? cred_q : st_q == PREPARO ? preco : '0);
    end else case (st_q)
      ESPERA: if (|io.B) begin
        sel_d = sel_de(io.B);
        st_d = PAGAMENTO;
      end
      PAGAMENTO: begin
        troco_d = valida ? '0 : moeda;
        vl_ld = io.MOEDA_V && !valida;
        // A valid coin reloads the idle timer, so its expiry that cycle is void.
        if (io.CANCELA || (t_done && !valida)) begin
          troco_d = troco_d + cred_n;
          st_d = ESPERA;
        end else if (cred_n >= preco) begin
          troco_d = cred_n - preco;
          st_d = PREPARO;
        end
      end
      PREPARO: if (t_done) st_d = ESPERA;
      default: st_d = ESPERA;
    endcase
    cred_d = st_d == PAGAMENTO ? cred_n : '0;
    t_ld = (st_d == PAGAMENTO && (st_q != PAGAMENTO || valida)) || (st_d == PREPARO && st_q != PREPARO);
    s_d = (st_d == PAGAMENTO || st_d == PREPARO) ? 4'b0001 << sel_d : 4'b0000;
    e_d = st_d == ERRO ? erro_prio(io.FSR, io.FSP, io.FSN) : 3'b000;
  end
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      st_q <= ESPERA;
      sel_q <= '0;
      cred_q <= '0;
      s_q <= '0;
      e_q <= '0;
      m_q <= 1'b1;
      lib_q <= 1'b0;
      troco_q <= '0;
      tv_q <= 1'b0;
      vl_q <= 1'b0;
    end else begin
      st_q <= st_d;
      sel_q <= sel_d;
      cred_q <= cred_d;
      s_q <= s_d;
      e_q <= e_d;
      m_q <= st_d == ESPERA;
      lib_q <= st_d == PREPARO;
      troco_q <= troco_d;
      tv_q <= troco_d != '0;
      vl_q <= vl_ld || (vl_q && !vl_done);
    end
  assign {io.S3, io.S2, io.S1, io.S0} = s_q;
  assign {io.SR, io.SP, io.SN} = e_q;
  assign io.VL = vl_q;
  assign io.M = m_q;
  assign io.LIBERA = lib_q;
  assign io.TROCO = troco_q;
  assign io.TROCO_V = tv_q;
endmodule

// File: tb/tb_controlador_maquina.sv
// tb_controlador_maquina: directed stimulus with a change scoreboard and level checks for controlador_maquina
module tb_controlador_maquina;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int checks = 0;
  int errors = 0;
  int n;
  int exp_q [$];
  controlador_maquina_if u ();
  controlador_maquina dut (.CLK(clk), .RST(rst), .io(u.slave));
  always #5 clk = ~clk;
  task automatic chk(input string nome, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", nome, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic botao(input logic [3:0] v);
    u.B = v;
    tick();
    u.B = 4'd0;
  endtask
  task automatic ins_moeda(input logic [3:0] v);
    u.MOEDA = v;
    u.MOEDA_V = 1'b1;
    tick();
    u.MOEDA_V = 1'b0;
    u.MOEDA = 4'd0;
  endtask
  task automatic espera_m;
    n = 0;
    while (!u.M && n < 3000) begin
      n++;
      tick();
    end
    chk("espera_timeout", u.M, 1);
  endtask
  function automatic int s_bits();
    return {u.S3, u.S2, u.S1, u.S0};
  endfunction
  function automatic int e_bits();
    return {u.SR, u.SP, u.SN};
  endfunction
  initial begin
    u.B = 4'd0; u.MOEDA = 4'd0; u.MOEDA_V = 1'b0; u.CANCELA = 1'b0;
    u.FSR = 1'b0; u.FSP = 1'b0; u.FSN = 1'b0;
    fork
      forever begin
        @(negedge clk);
        if (!rst && u.TROCO_V) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL troco_inesperado got %0d expected no strobe", u.TROCO);
          end else begin
            int e;
            e = exp_q.pop_front();
            if (u.TROCO !== W_TROCO'(e)) begin
              errors++;
              $display("FAIL troco_valor got %0d expected %0d", u.TROCO, e);
            end
          end
        end
      end
      begin
        #1 rst = 1'b1;
        #2;
        chk("rst_M", u.M, 1);
        chk("rst_S", s_bits(), 0);
        chk("rst_LIBERA", u.LIBERA, 0);
        chk("rst_TROCO_V", u.TROCO_V, 0);
        chk("rst_TROCO", u.TROCO, 0);
        chk("rst_erros", {e_bits(), u.VL}, 0);
        #20;
        @(negedge clk) rst = 1'b0;
        tick();
        botao(4'b0101);
        chk("prio_sel_S", s_bits(), 4'b0001);
        chk("prio_M", u.M, 0);
        u.CANCELA = 1'b1; tick(); u.CANCELA = 1'b0;
        chk("cancela_zero_M", u.M, 1);
        exp_q.push_back(5);
        ins_moeda(5);
        chk("espera_moeda_M", u.M, 1);
        botao(4'b0100);
        chk("t1_S", s_bits(), 4'b0100);
        chk("t1_M", u.M, 0);
        ins_moeda(5);
        chk("t1_LIBERA", u.LIBERA, 1);
        chk("t1_S_preparo", s_bits(), 4'b0100);
        n = 0;
        while (u.LIBERA && n < 1000) begin n++; tick(); end
        chk("t1_preparo_len", n, 500);
        chk("t1_M_fim", u.M, 1);
        chk("t1_S_fim", s_bits(), 0);
        botao(4'b1000);
        ins_moeda(5);
        ins_moeda(2);
        chk("t2_LIBERA_antes", u.LIBERA, 0);
        botao(4'b0001);
        chk("t2_B_ignorado", s_bits(), 4'b1000);
        exp_q.push_back(2);
        ins_moeda(5);
        chk("t2_LIBERA", u.LIBERA, 1);
        espera_m();
        botao(4'b0010);
        exp_q.push_back(3);
        ins_moeda(3);
        chk("t3_VL", u.VL, 1);
        chk("t3_S", s_bits(), 4'b0010);
        chk("t3_LIBERA", u.LIBERA, 0);
        n = 0;
        while (u.VL && n < 1000) begin n++; tick(); end
        chk("t3_VL_len", n, 200);
        ins_moeda(1);
        chk("t3_credito_inalterado", u.LIBERA, 0);
        ins_moeda(1);
        chk("t3_LIBERA", u.LIBERA, 1);
        espera_m();
        botao(4'b0010);
        exp_q.push_back(7);
        ins_moeda(7);
        repeat (50) tick();
        exp_q.push_back(9);
        ins_moeda(9);
        n = 0;
        while (u.VL && n < 1000) begin n++; tick(); end
        chk("vl_reinicia_len", n, 200);
        u.CANCELA = 1'b1; tick(); u.CANCELA = 1'b0;
        chk("vl_cancela_M", u.M, 1);
        botao(4'b0010);
        ins_moeda(1);
        exp_q.push_back(1);
        u.CANCELA = 1'b1; tick(); u.CANCELA = 1'b0;
        chk("t4_M", u.M, 1);
        chk("t4_S", s_bits(), 0);
        botao(4'b0100);
        ins_moeda(2);
        exp_q.push_back(4);
        u.CANCELA = 1'b1;
        ins_moeda(2);
        u.CANCELA = 1'b0;
        chk("moeda_cancela_M", u.M, 1);
        botao(4'b0010);
        n = 0;
        while (!u.M && n < 3000) begin n++; tick(); end
        chk("t4_timeout_len", n, 1000);
        botao(4'b1000);
        ins_moeda(10);
        chk("t5_LIBERA", u.LIBERA, 1);
        tick(); tick();
        exp_q.push_back(10);
        u.FSP = 1'b1; tick();
        chk("t5_SP", e_bits(), 3'b010);
        chk("t5_LIBERA_erro", u.LIBERA, 0);
        chk("t5_S_erro", s_bits(), 0);
        chk("t5_M_erro", u.M, 0);
        u.FSR = 1'b1; tick();
        chk("t5_SR", e_bits(), 3'b100);
        u.FSR = 1'b0; u.FSP = 1'b0; tick();
        chk("t5_M_fim", u.M, 1);
        chk("t5_erros_fim", e_bits(), 0);
        botao(4'b0001);
        ins_moeda(1);
        tick();
        chk("t6_LIBERA", u.LIBERA, 1);
        #2 rst = 1'b1;
        #1;
        chk("t6_LIBERA_async", u.LIBERA, 0);
        chk("t6_M_async", u.M, 1);
        @(negedge clk) rst = 1'b0;
        repeat (5) tick();
        chk("t6_M_pos", u.M, 1);
        chk("t6_LIBERA_pos", u.LIBERA, 0);
        repeat (3) tick();
        chk("fila_vazia", exp_q.size(), 0);
      end
    join_any
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
  localparam int W_TROCO = 5;
endmodule

// File: doc/controlador_maquina.md
Name: controlador_maquina

Overview:
Upstream control FSM of the coffee machine. It takes drink-selection buttons, coin strobes, a cancel button and three sensor fault lines. It produces the one-hot selection, error and mode lines consumed port-for-port by the display decoder stage (S0..S3, SR, SP, SN, VL, M). It also tracks credit, times the brew, and reports change to the coin return unit.

Parameters:
PRECO_S0, 1, price of CE01 in coin units
PRECO_S1, 2, price of CL02
PRECO_S2, 5, price of CC05
PRECO_S3, 10, price of CP10
W_CREDITO, 5, credit/change width; must satisfy 2*max(PRECO)-1 < 2^W_CREDITO
T_PAGAMENTO, 1000, idle cycles in payment before auto-refund
T_PREPARO, 500, brew duration in cycles
T_ERRO_VL, 200, cycles VL stays high after an invalid coin

Ports:
CLK  in  1  system clock, rising edge
RST  in  1  asynchronous reset, active-high
B  in  4  drink buttons, single-cycle synchronous pulses, bit k selects Sk
MOEDA  in  4  coin value, sampled when MOEDA_V=1
MOEDA_V  in  1  coin strobe, single cycle
CANCELA  in  1  cancel pulse
FSR, FSP, FSN  in  1 each  sensor faults (water, powder, cup), level, active-high
S0, S1, S2, S3  out  1 each  selected drink, one-hot or all zero
SR, SP, SN  out  1 each  displayed sensor error, at most one high
VL  out  1  invalid-money error
M  out  1  standby mode
LIBERA  out  1  dispense valve, high during brew
TROCO  out  W_CREDITO  change/refund amount, valid with TROCO_V
TROCO_V  out  1  single-cycle change strobe

Behaviour:
- One clock (CLK). RST is asynchronous, active-high. All outputs are registered.
- Reset values: state=ESPERA, M=1, LIBERA=0, TROCO=0, TROCO_V=0, credit=0, all timers cleared. S*, SR, SP, SN and VL are all 0.
- States: ESPERA, PAGAMENTO, PREPARO, ERRO. Each output reflects the state one cycle after the transition edge.
- Fault check, any state: any FSx high sends the FSM to ERRO on the next edge. This has priority over every other event in the same cycle.
- ESPERA:
  - M=1.
  - Any B bit set: latch sel (lowest set index wins), clear credit, go to PAGAMENTO.
  - Coins and CANCELA are ignored. A coin here is refunded immediately: TROCO=MOEDA, TROCO_V=1.
- PAGAMENTO:
  - M=0, S[sel]=1.
  - Valid coin: MOEDA in {1,2,5,10} adds to credit and restarts the T_PAGAMENTO timer.
  - Invalid coin:
    - Rejected; credit unchanged.
    - Refunded: TROCO=MOEDA, TROCO_V=1.
    - VL=1 for T_ERRO_VL cycles. A new invalid coin restarts that window.
  - Credit reaching or exceeding price[sel]: go to PREPARO. If credit>price, emit TROCO=credit-price with TROCO_V=1 in the same cycle.
  - CANCELA, or payment timer expiry: refund credit (TROCO_V only if credit>0), go to ESPERA.
  - Coin and CANCELA in the same cycle: the coin is added first, then the whole credit is refunded.
  - B presses are ignored in this state.
- PREPARO:
  - S[sel]=1, LIBERA=1.
  - The T_PREPARO timer runs; at expiry, LIBERA=0 and go to ESPERA.
  - B, coins and CANCELA are ignored; coins are refunded as in ESPERA.
- ERRO:
  - LIBERA=0, S*=0, M=0.
  - Exactly one of SR/SP/SN is high, priority SR>SP>SN, tracking live sensor levels.
  - On entry from PAGAMENTO or PREPARO, refund the paid amount once (credit, or price[sel] if brewing), TROCO_V single cycle.
  - When all FSx are low, go to ESPERA.
- Reset mid-operation: state and credit are lost, no refund is emitted, and outputs return to reset values immediately (asynchronous).
- All credit arithmetic is unsigned W_CREDITO; no wrap is possible under the parameter constraint.

Decomposition:
- Package maquina_pkg: state encoding, the PRECO array indexed by sel, the valid coin set, and the error-priority constant.
- One sub-module, temporizador: a loadable down-counter with load, enable and done pulse. It is instantiated twice, for payment/brew (shared, reloaded per state) and for the VL window.

Test Plan:
- Press B=0100, insert coins 5 -> S2=1 M=0, then PREPARO with LIBERA=1 for T_PREPARO cycles, TROCO_V never asserted, then M=1.
- Press B=1000, insert 5,2,5 -> PREPARO entered on the third coin, TROCO=2 with TROCO_V=1 for one cycle.
- Press B=0010, insert MOEDA=3 -> VL=1 for T_ERRO_VL cycles, TROCO=3 strobed, credit unchanged, S1 stays 1.
- Press B=0001, insert 2... (use B=0010, insert 1), then CANCELA -> TROCO=1 strobed, state ESPERA, M=1; a separate run with no coin for T_PAGAMENTO cycles -> ESPERA with no TROCO_V.
- In PREPARO for S3, raise FSP then FSR together -> SR=1 only, LIBERA=0, TROCO=10 strobed; drop both -> ESPERA.
- Assert RST mid-PREPARO -> LIBERA=0 and M=1 asynchronously, no TROCO_V on release.
